// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to the
// instruction cache and buffers {instruction, PC+4} pairs in a small FIFO
// that feeds decode. Supports redirect flush, decode back-pressure and a
// sticky halt that stops fetching but lets buffered entries drain.
module fetch_queue_unit #(
    parameter int                WORD_W  = 32,
    parameter int                DEPTH   = 4,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic                       CLK,
    input  logic                       nRST,
    output logic                       imemREN,
    output logic [WORD_W-1:0]          imemaddr,
    input  logic [WORD_W-1:0]          imemload,
    input  logic                       ihit,
    input  logic                       redirect,
    input  logic [WORD_W-1:0]          redirect_pc,
    input  logic                       halt,
    input  logic                       deq,
    output logic                       out_valid,
    output logic [WORD_W-1:0]          out_instr,
    output logic [WORD_W-1:0]          out_pc_plus_4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Queue storage, one instruction and its PC+4 per entry.
    logic [WORD_W-1:0] instr_mem [DEPTH];
    logic [WORD_W-1:0] pc4_mem   [DEPTH];

    logic [WORD_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  occupancy;
    logic              halted;

    logic              push;
    logic              pop;
    logic [WORD_W-1:0] fetch_pc_plus_4;

    // Request generation and the push/pop qualifiers; redirect overrides both.
    always_comb begin
        imemREN         = !halted && (occupancy != FULL_COUNT);
        imemaddr        = fetch_pc;
        fetch_pc_plus_4 = fetch_pc + WORD_W'(4);
        out_valid       = (occupancy != '0);
        push            = ihit && imemREN && !redirect;
        pop             = deq && out_valid && !redirect;
        count           = occupancy;
    end

    // Head of queue, forced to zero when nothing is buffered.
    always_comb begin
        out_instr     = '0;
        out_pc_plus_4 = '0;
        if (out_valid) begin
            out_instr     = instr_mem[rd_ptr];
            out_pc_plus_4 = pc4_mem[rd_ptr];
        end
    end

    // Control state: fetch PC, pointers, occupancy and the sticky halt flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_pc  <= PC_INIT;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            halted    <= 1'b0;
        end else begin
            if (halt) begin
                halted <= 1'b1;
            end
            if (redirect) begin
                fetch_pc  <= redirect_pc;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc_plus_4;
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   occupancy <= occupancy + CNT_W'(1);
                    2'b01:   occupancy <= occupancy - CNT_W'(1);
                    default: occupancy <= occupancy;
                endcase
            end
        end
    end

    // Entry write on push.
    // NOTE: the storage array has no reset; occupancy gates the head outputs,
    // so stale contents are never observable and the array stays plain RAM.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr] <= imemload;
            pc4_mem[wr_ptr]   <= fetch_pc_plus_4;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit (DEPTH=4, PC_INIT=0).
// The instruction cache is modelled as a zero-wait memory whose word at
// address A is 32'hC000_0000 + A, so expected head values are hand-derived.
module tb_fetch_queue_unit;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus_4;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_queue_unit #(
        .WORD_W (32),
        .DEPTH  (4),
        .PC_INIT(32'h0)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .imemload     (imemload),
        .ihit         (ihit),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .deq          (deq),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc_plus_4(out_pc_plus_4),
        .count        (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cache data model: stimulus only, derived from the requested address.
    always_comb imemload = 32'hC000_0000 + imemaddr;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST        = 1'b0;
        ihit        = 1'b0;
        deq         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ren",   32'(imemREN),   32'd1);
        check("rst_addr",  imemaddr,       32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr,      32'h0);
        check("rst_pc4",   out_pc_plus_4,  32'h0);
        check("rst_count", 32'(count),     32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // 1: fill with zero-wait hits, no dequeue
        ihit = 1'b1;
        deq  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_addr%0d", i), imemaddr, 32'(4 * i));
            step();
        end
        check("fill_count", 32'(count),     32'd4);
        check("fill_ren",   32'(imemREN),   32'd0);
        check("fill_instr", out_instr,      32'hC000_0000);
        check("fill_pc4",   out_pc_plus_4,  32'h4);
        check("fill_addr",  imemaddr,       32'h10);

        // 2: streaming with one pop per cycle, pointers wrap
        deq = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("stream_pc4_%0d", k),   out_pc_plus_4, 32'(4 * (k + 1)));
            check($sformatf("stream_instr_%0d", k), out_instr,     32'hC000_0000 + 32'(4 * k));
            step();
        end
        check("stream_count", 32'(count),    32'd3);
        check("stream_addr",  imemaddr,      32'h24);
        check("stream_head",  out_pc_plus_4, 32'h1C);

        // 3: redirect with simultaneous hit and dequeue
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        ihit        = 1'b1;
        deq         = 1'b1;
        step();
        redirect = 1'b0;
        ihit     = 1'b0;
        deq      = 1'b0;
        check("redir_count", 32'(count),     32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_addr",  imemaddr,       32'h100);
        check("redir_instr", out_instr,      32'h0);
        step();
        check("redir_nodata", 32'(out_valid), 32'd0);
        check("redir_hold",   imemaddr,       32'h100);

        // 4: ihit toggling 1,0,1 with deq=1 from empty
        deq  = 1'b1;
        ihit = 1'b1;
        step();
        check("tog_valid1", 32'(out_valid), 32'd1);
        check("tog_count1", 32'(count),     32'd1);
        check("tog_instr1", out_instr,      32'hC000_0100);
        check("tog_pc4_1",  out_pc_plus_4,  32'h104);
        ihit = 1'b0;
        step();
        check("tog_valid0", 32'(out_valid), 32'd0);
        check("tog_addr0",  imemaddr,       32'h104);
        ihit = 1'b1;
        step();
        check("tog_valid2", 32'(out_valid), 32'd1);
        check("tog_pc4_2",  out_pc_plus_4,  32'h108);
        ihit = 1'b0;
        step();
        step();
        check("deq_empty_count", 32'(count), 32'd0);

        // 5: halt at count=2, drain, redirect while halted
        deq  = 1'b0;
        ihit = 1'b1;
        step();
        step();
        check("halt_pre_count", 32'(count), 32'd2);
        halt = 1'b1;
        ihit = 1'b0;
        step();
        halt = 1'b0;
        check("halt_ren",   32'(imemREN), 32'd0);
        check("halt_count", 32'(count),   32'd2);
        ihit = 1'b1;
        deq  = 1'b1;
        check("halt_head0", out_pc_plus_4, 32'h10C);
        step();
        check("halt_count1", 32'(count),    32'd1);
        check("halt_head1",  out_pc_plus_4, 32'h110);
        step();
        check("halt_valid", 32'(out_valid), 32'd0);
        step();
        check("halt_count0", 32'(count), 32'd0);
        check("halt_frozen", imemaddr,   32'h110);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("halt_redir_addr", imemaddr,     32'h200);
        check("halt_redir_ren",  32'(imemREN), 32'd0);
        step();
        check("halt_redir_count", 32'(count), 32'd0);

        // 6: asynchronous reset mid-fill
        ihit = 1'b0;
        deq  = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        ihit = 1'b1;
        step();
        step();
        check("arst_pre_count", 32'(count), 32'd2);
        check("arst_pre_addr",  imemaddr,   32'h8);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_count", 32'(count),     32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ren",   32'(imemREN),   32'd1);
        check("arst_addr",  imemaddr,       32'h0);
        check("arst_instr", out_instr,      32'h0);
        check("arst_pc4",   out_pc_plus_4,  32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        ihit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
